// File: rtl/mem_fill_ctrl.sv
// Write-side fill controller for a two-page item memory. Each start pulse closes the
// current page, reports how many items it holds, and opens the other page for filling.
module mem_fill_ctrl #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  wr_en,
    output logic [ADDR_BITS:0]    wr_addr,
    output logic [DATA_WIDTH-1:0] wr_dat,
    output logic [ADDR_BITS:0]    count_out,
    output logic                  count_page,
    output logic                  count_ready,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] ONE        = {{ADDR_BITS{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    page_q, page_d;
    logic [ADDR_BITS:0]      cnt_q, cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_BITS:0]      wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_dat_q, wr_dat_d;
    logic [ADDR_BITS:0]      count_out_q, count_out_d;
    logic                    count_page_q, count_page_d;
    logic                    count_ready_q, count_ready_d;
    logic                    overflow_q, overflow_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            page_q        <= 1'b0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_dat_q      <= '0;
            count_out_q   <= '0;
            count_page_q  <= 1'b0;
            count_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_q        <= page_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_dat_q      <= wr_dat_d;
            count_out_q   <= count_out_d;
            count_page_q  <= count_page_d;
            count_ready_q <= count_ready_d;
            overflow_q    <= overflow_d;
        end
    end

    // A start while a page is open wins over the item: the closed page's count is taken
    // before the coincident item, which lands at entry 0 of the freshly opened page.
    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        cnt_d         = cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_dat_d      = wr_dat_q;
        count_out_d   = count_out_q;
        count_page_d  = count_page_q;
        count_ready_d = 1'b0;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    page_d     = 1'b0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            FILL, FULL: begin
                if (start) begin
                    count_out_d   = cnt_q;
                    count_page_d  = page_q;
                    count_ready_d = 1'b1;
                    state_d       = FILL;
                    page_d        = ~page_q;
                    cnt_d         = '0;
                    overflow_d    = 1'b0;
                    if (din_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {~page_q, {ADDR_BITS{1'b0}}};
                        wr_dat_d  = din;
                        cnt_d     = ONE;
                    end
                end else if (din_valid) begin
                    if (state_q == FILL) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {page_q, cnt_q[ADDR_BITS-1:0]};
                        wr_dat_d  = din;
                        cnt_d     = cnt_q + ONE;
                        if (cnt_d == FULL_COUNT) begin
                            state_d = FULL;
                        end
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_dat      = wr_dat_q;
    assign count_out   = count_out_q;
    assign count_page  = count_page_q;
    assign count_ready = count_ready_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Directed self-checking bench for mem_fill_ctrl: reset, basic fill, overflow,
// start/data coincidence, back-to-back starts and mid-crossing reset.
module tb_mem_fill_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        din_valid;
    logic [35:0] din;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [35:0] wr_dat;
    logic [6:0]  count_out;
    logic        count_page;
    logic        count_ready;
    logic        overflow;

    int total;
    int bad;

    mem_fill_ctrl #(.DATA_WIDTH(36), .ADDR_BITS(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .din_valid   (din_valid),
        .din         (din),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_dat      (wr_dat),
        .count_out   (count_out),
        .count_page  (count_page),
        .count_ready (count_ready),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        reset     = 1'b1;
        step();
        step();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        start     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        reset     = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_dat, count_out, count_page, count_ready, overflow} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got wr_en=%0b wr_addr=%h wr_dat=%h count_out=%0d page=%0b ready=%0b ovf=%0b, expected all zero",
                     wr_en, wr_addr, wr_dat, count_out, count_page, count_ready, overflow);
        end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_pre_start();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din       = 36'h0_DEAD_0000 + 36'(i);
            step();
            total++;
            if (wr_en !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_no_write: wr_en=%0b expected 0", wr_en);
            end
        end
        din_valid = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b0 || wr_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_start: count_ready=%0b wr_en=%0b expected 0 0", count_ready, wr_en);
        end
        din_valid = 1'b1;
        din       = 36'h1_2345_6789;
        step();
        din_valid = 1'b0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h00 || wr_dat !== 36'h1_2345_6789) begin
            bad++;
            $display("[TB] FAIL first_item: wr_en=%0b wr_addr=%h wr_dat=%h expected 1 00 123456789",
                     wr_en, wr_addr, wr_dat);
        end
    endtask

    task automatic test_basic_fill();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din       = 36'hA_0000_0000 + 36'(i);
            step();
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 7'(i) || wr_dat !== 36'hA_0000_0000 + 36'(i)) begin
                bad++;
                $display("[TB] FAIL basic_write%0d: wr_en=%0b wr_addr=%h wr_dat=%h expected 1 %h %h",
                         i, wr_en, wr_addr, wr_dat, 7'(i), 36'hA_0000_0000 + 36'(i));
            end
        end
        din_valid = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b1 || count_out !== 7'd5 || count_page !== 1'b0 || wr_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_close: ready=%0b count_out=%0d page=%0b wr_en=%0b expected 1 5 0 0",
                     count_ready, count_out, count_page, wr_en);
        end
        din_valid = 1'b1;
        din       = 36'hB_0000_0001;
        step();
        din_valid = 1'b0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h40 || count_ready !== 1'b0 || count_out !== 7'd5) begin
            bad++;
            $display("[TB] FAIL basic_page1: wr_en=%0b wr_addr=%h ready=%0b count_out=%0d expected 1 40 0 5",
                     wr_en, wr_addr, count_ready, count_out);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            din_valid = 1'b1;
            din       = 36'hC_0000_0000 + 36'(k);
            step();
            total++;
            if (k <= 64) begin
                if (wr_en !== 1'b1 || wr_addr !== 7'(k - 1) || overflow !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fill_item%0d: wr_en=%0b wr_addr=%h ovf=%0b expected 1 %h 0",
                             k, wr_en, wr_addr, overflow, 7'(k - 1));
                end
            end else begin
                if (wr_en !== 1'b0 || overflow !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL drop_item%0d: wr_en=%0b ovf=%0b expected 0 1", k, wr_en, overflow);
                end
            end
        end
        din_valid = 1'b0;
        step();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_sticky: ovf=%0b expected 1", overflow);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b1 || count_out !== 7'd64 || count_page !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_close: ready=%0b count_out=%0d page=%0b ovf=%0b expected 1 64 0 0",
                     count_ready, count_out, count_page, overflow);
        end
    endtask

    // Runs straight after test_overflow, so page 1 is open and empty.
    task automatic test_coincident();
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din       = 36'hD_0000_0000 + 36'(i);
            step();
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 7'h40 + 7'(i)) begin
                bad++;
                $display("[TB] FAIL coin_pre%0d: wr_en=%0b wr_addr=%h expected 1 %h",
                         i, wr_en, wr_addr, 7'h40 + 7'(i));
            end
        end
        start     = 1'b1;
        din_valid = 1'b1;
        din       = 36'hE_0000_00EE;
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b1 || count_out !== 7'd3 || count_page !== 1'b1 ||
            wr_en !== 1'b1 || wr_addr !== 7'h00 || wr_dat !== 36'hE_0000_00EE) begin
            bad++;
            $display("[TB] FAIL coin_start: ready=%0b count_out=%0d page=%0b wr_en=%0b wr_addr=%h wr_dat=%h expected 1 3 1 1 00 E000000EE",
                     count_ready, count_out, count_page, wr_en, wr_addr, wr_dat);
        end
        din = 36'hE_0000_00EF;
        step();
        din_valid = 1'b0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h01) begin
            bad++;
            $display("[TB] FAIL coin_next: wr_en=%0b wr_addr=%h expected 1 01", wr_en, wr_addr);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b1 || count_out !== 7'd2 || count_page !== 1'b0) begin
            bad++;
            $display("[TB] FAIL coin_close: ready=%0b count_out=%0d page=%0b expected 1 2 0",
                     count_ready, count_out, count_page);
        end
    endtask

    // Runs after test_coincident, so page 1 is open and empty.
    task automatic test_back_to_back();
        start = 1'b1;
        step();
        total++;
        if (count_ready !== 1'b1 || count_out !== 7'd0 || count_page !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_first: ready=%0b count_out=%0d page=%0b expected 1 0 1",
                     count_ready, count_out, count_page);
        end
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b1 || count_out !== 7'd0 || count_page !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_second: ready=%0b count_out=%0d page=%0b expected 1 0 0",
                     count_ready, count_out, count_page);
        end
        step();
        total++;
        if (count_ready !== 1'b0 || count_out !== 7'd0 || count_page !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_hold: ready=%0b count_out=%0d page=%0b expected 0 0 0",
                     count_ready, count_out, count_page);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din_valid = 1'b1;
            din       = 36'hF_0000_0000 + 36'(i);
            step();
        end
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h09) begin
            bad++;
            $display("[TB] FAIL mid_last_write: wr_en=%0b wr_addr=%h expected 1 09", wr_en, wr_addr);
        end
        din_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_dat, count_out, count_page, count_ready, overflow} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset_clear: wr_en=%0b wr_addr=%h wr_dat=%h count_out=%0d page=%0b ready=%0b ovf=%0b expected all zero",
                     wr_en, wr_addr, wr_dat, count_out, count_page, count_ready, overflow);
        end
        step();
        step();
        reset = 1'b0;
        total++;
        if (count_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_ready: ready=%0b expected 0", count_ready);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_restart_ready: ready=%0b expected 0", count_ready);
        end
        din_valid = 1'b1;
        din       = 36'h5_5555_5555;
        step();
        din_valid = 1'b0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h00 || wr_dat !== 36'h5_5555_5555) begin
            bad++;
            $display("[TB] FAIL mid_restart_write: wr_en=%0b wr_addr=%h wr_dat=%h expected 1 00 555555555",
                     wr_en, wr_addr, wr_dat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pre_start();
        test_basic_fill();
        test_overflow();
        test_coincident();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 36: width of the stored item.
REQ-002 SHALL have parameter ADDR_BITS, default 6: per-page address width, giving 64 entries per page.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse marking a new bunch crossing.
REQ-006 din_valid  input  1  din holds an item to store this cycle.
REQ-007 din  input  DATA_WIDTH  item data.
REQ-008 wr_en  output  1  memory write enable.
REQ-009 wr_addr  output  ADDR_BITS+1  memory address; MSB = page, low bits = entry.
REQ-010 wr_dat  output  DATA_WIDTH  memory write data.
REQ-011 count_out  output  ADDR_BITS+1  items written into the page just closed; feeds the reader's initial count.
REQ-012 count_page  output  1  page that count_out describes.
REQ-013 count_ready  output  1  one-cycle pulse: count_out/count_page are valid.
REQ-014 overflow  output  1  sticky per crossing: an item was dropped because the page was full.

Function
REQ-015 SHALL implement states IDLE, FILL, FULL.
REQ-016 IDLE: din_valid ignored, no writes; start -> FILL, page = 0, entry counter = 0, no count_ready pulse.
REQ-017 FILL: each din_valid cycle accepts one item, writes it at {page, entry counter}, then increments the counter.
REQ-018 FILL -> FULL when the counter reaches 2^ADDR_BITS (64); the counter never wraps.
REQ-019 FULL: din_valid cycles produce no write and set overflow.
REQ-020 Write latency SHALL be exactly 1 cycle: din_valid at cycle N gives wr_en=1 and the registered wr_addr/wr_dat at N+1.
REQ-021 wr_en SHALL be 0 in any cycle not preceded by an accepted item.
REQ-022 start in FILL or FULL, cycle N, does all of the following:
- closes the current page;
- at N+1: count_out = items accepted through N-1 (0..64), count_page = closed page, count_ready = 1 for that one cycle;
- toggles page, clears the entry counter and overflow, and enters FILL.
REQ-023 din_valid coincident with start SHALL be written to entry 0 of the new page, never to the closed page.
REQ-024 A crossing with zero items SHALL report count_out = 0 with a normal count_ready pulse.
REQ-025 A crossing with exactly 64 items SHALL report count_out = 64, overflow = 0; each further item sets overflow.
REQ-026 Back-to-back start pulses (consecutive cycles) SHALL each close a page and pulse count_ready, alternating count_page.
REQ-027 overflow SHALL stay set until the next start or reset.
REQ-028 count_out and count_page SHALL hold their value between count_ready pulses.

Reset
REQ-029 reset SHALL immediately force all of the following, regardless of clk:
- state = IDLE, page = 0, entry counter = 0;
- wr_en = 0, wr_addr = 0, wr_dat = 0;
- count_out = 0, count_page = 0, count_ready = 0, overflow = 0.
REQ-030 Reset asserted mid-crossing SHALL discard the open page with no count_ready pulse; the next start after release behaves as from IDLE (page 0).

Verification
REQ-031 Reset, start, 5 items on consecutive cycles, start -> wr_addr 0x00..0x04 one cycle after each item; count_out = 5, count_page = 0, count_ready pulse; next items go to 0x40.
REQ-032 Fill 70 items in one crossing, then start -> writes to entries 0..63 only; overflow = 1 from the cycle after item 65; count_out = 64; overflow cleared after start.
REQ-033 start with din_valid = 1 in the same cycle -> item written to entry 0 of the new page; closed-page count excludes it.
REQ-034 Two start pulses on consecutive cycles with no data -> two count_ready pulses, count_out = 0 both times, count_page alternating.
REQ-035 din_valid before the first start after reset -> no wr_en; after start, first item lands at wr_addr 0x00.
REQ-036 Reset asserted mid-crossing with 10 items written -> outputs clear immediately, no count_ready; the next start selects page 0 with no count_ready pulse.
